// File: rtl/fpu_pkg.sv
// fpu_pkg: shared IEEE-754 single-precision types, constants and helpers for the fpu blocks.
package fpu_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;
  typedef enum logic [2:0] {ACCEPT, ALIGN, ADD, NORM, OUT} acc_state_t;
  // Denormals flush to zero, so exp==0 contributes no hidden bit and no fraction.
  function automatic logic [FP_MAN_W:0] fp_mant(input fp32_t x);
    return (x.exp == '0) ? '0 : {1'b1, x.man};
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational 25-bit leading-zero counter; an all-zero input yields 25.
module fp_lzc (
  input  logic [24:0] a_i,
  output logic [4:0]  cnt_o
);
  always_comb begin
    cnt_o = 5'd25;
    for (int i = 0; i < 25; i++)
      if (a_i[i]) cnt_o = 5'(24 - i);
  end
endmodule

// File: rtl/fp_accumulator.sv
// fp_accumulator: sequential single-precision frame accumulator, one element per 4 cycles.
module fp_accumulator
  import fpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);
  acc_state_t       state_q, state_d;
  fp32_t            acc_q, op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             nan_q, last_q, sign_q, sub_q;
  logic [23:0]      big_q, sml_q;
  logic [7:0]       exp_q;
  logic [24:0]      sum_q;
  logic             a_big;
  logic [7:0]       diff;
  logic [23:0]      sml_sh;
  logic [4:0]       lz;
  logic signed [9:0] e_n;
  logic [22:0]      man_n;
  fp32_t            res;

  fp_lzc u_lzc (.a_i(sum_q), .cnt_o(lz));

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_valid ? (nan_q ? FP_QNAN : acc_q) : '0;
  assign out_count = out_valid ? cnt_q : '0;

  always_comb begin
    a_big  = {acc_q.exp, acc_q.man} >= {op_q.exp, op_q.man};
    diff   = a_big ? acc_q.exp - op_q.exp : op_q.exp - acc_q.exp;
    sml_sh = (diff >= 8'd25) ? '0 : (a_big ? fp_mant(op_q) : fp_mant(acc_q)) >> diff;
  end

  // Hidden bit belongs at bit 23 of the 25-bit sum, hence the lz-1 left shift.
  always_comb begin
    e_n   = sum_q[24] ? $signed({2'b00, exp_q}) + 10'sd1
                      : $signed({2'b00, exp_q}) + 10'sd1 - $signed({5'b00000, lz});
    man_n = sum_q[24] ? sum_q[23:1] : 23'(sum_q << (lz - 5'd1));
    res   = (sum_q == '0)      ? '0 :
            (e_n <= 10'sd0)    ? {sign_q, 31'd0} :
            (e_n >= 10'sd255)  ? {sign_q, FP_PINF[30:0]} :
                                 {sign_q, e_n[7:0], man_n};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:  state_d = in_valid ? ALIGN : ACCEPT;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = last_q ? OUT : ACCEPT;
      OUT:     state_d = out_ready ? ACCEPT : OUT;
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      nan_q   <= 1'b0;
      last_q  <= 1'b0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      big_q   <= '0;
      sml_q   <= '0;
      exp_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ACCEPT: if (in_valid) begin
          op_q   <= in_data;
          last_q <= in_last;
          cnt_q  <= cnt_q + CNT_W'(cnt_q != '1);
          nan_q  <= nan_q | (in_data[30:23] == 8'hFF);
        end
        ALIGN: begin
          big_q  <= a_big ? fp_mant(acc_q) : fp_mant(op_q);
          sml_q  <= sml_sh;
          exp_q  <= a_big ? acc_q.exp : op_q.exp;
          sign_q <= a_big ? acc_q.sign : op_q.sign;
          sub_q  <= acc_q.sign ^ op_q.sign;
        end
        ADD: sum_q <= sub_q ? {1'b0, big_q} - {1'b0, sml_q} : {1'b0, big_q} + {1'b0, sml_q};
        NORM: acc_q <= res;
        OUT: if (out_ready) begin
          acc_q <= '0;
          cnt_q <= '0;
          nan_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: directed frame vectors plus backpressure and reset sequences.
module tb_fp_accumulator;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] out_count;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    bit          two;
    logic [31:0] sum;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[11];

  fp_accumulator #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for data %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_timeout: out_valid stayed 0 after %0d cycles", lat);
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_pop", 32'(out_valid), 32'd0);
  endtask

  task automatic frame2(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sum, input logic [15:0] cnt);
    int lat;
    send(a, 1'b0);
    send(b, 1'b1);
    wait_out(lat);
    chk({nm, "_lat"}, 32'(lat), 32'd3);
    chk({nm, "_data"}, out_data, sum);
    chk({nm, "_count"}, 32'(out_count), 32'(cnt));
    pop();
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 16'd2};
    vecs[1]  = '{32'h41200000, 32'hC2C80000, 1'b1, 32'hC2B40000, 16'd2};
    vecs[2]  = '{32'h40400000, 32'hC0400000, 1'b1, 32'h00000000, 16'd2};
    vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 16'd2};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 16'd2};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 16'd2};
    vecs[6]  = '{32'h00400000, 32'h3F800000, 1'b1, 32'h3F800000, 16'd2};
    vecs[7]  = '{32'h00800000, 32'h80800001, 1'b1, 32'h80000000, 16'd2};
    vecs[8]  = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 16'd2};
    vecs[9]  = '{32'hC0490FDB, 32'h0, 1'b0, 32'hC0490FDB, 16'd1};
    vecs[10] = '{32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 16'd2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].d0, !vecs[i].two);
      if (vecs[i].two) send(vecs[i].d1, 1'b1);
      wait_out(lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].sum);
      chk($sformatf("vec%0d_count", i), 32'(out_count), 32'(vecs[i].cnt));
      pop();
    end

    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40800000, 1'b1);
    wait_out(lat);
    chk("three_data", out_data, 32'h40E00000);
    chk("three_count", 32'(out_count), 32'd3);
    pop();

    send(32'h3FC00000, 1'b1);
    wait_out(lat);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, 32'h3FC00000);
      chk("bp_count", 32'(out_count), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    pop();
    frame2("after_bp", 32'h40000000, 32'h3F000000, 32'h40200000, 16'd2);

    send(32'h3F800000, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    frame2("after_midrst", 32'h40000000, 32'h3F000000, 32'h40200000, 16'd2);

    send(32'h3FC00000, 1'b1);
    wait_out(lat);
    chk("pend_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("pendrst_out_valid", 32'(out_valid), 32'd0);
    chk("pendrst_out_data", out_data, 32'd0);
    chk("pendrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    frame2("after_pendrst", 32'h40000000, 32'h3F000000, 32'h40200000, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
